// File: rtl/llsc_reservation_ctrl.sv
// llsc_reservation_ctrl
// Owns the LL/SC reservation (link bit and link address) for the memory stage.
// It picks the LL/SC from the memory-stage slots, runs the conditional-store
// handshake with the D-cache and reports a one-cycle SC result to the pipeline.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ll_valid         per-slot LL valid in memory stage
//   sc_valid         per-slot SC valid in memory stage
//   mem_addr         per-slot physical address (slot i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   except_valid     exception/flush commit
//   eret_valid       ERET commit
//   snoop_valid      external store/invalidate observed
//   snoop_addr       snooped address
//   dc_req, dc_addr  SC store request and address to the D-cache
//   dc_ack           D-cache accepted the SC store
//   sc_stall         hold the memory stage while an SC store is outstanding
//   sc_result_valid  one-cycle SC completion pulse
//   sc_result        1 = SC succeeded
//   sc_slot          slot of the completing SC
//   ll_bit           CP0 LLbit
//   link_addr        CP0 LLAddr
module llsc_reservation_ctrl #(
  parameter int ISSUE_NUM   = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_OFFSET = 4,
  parameter int SLOT_W      = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ISSUE_NUM-1:0]            ll_valid,
  input  logic [ISSUE_NUM-1:0]            sc_valid,
  input  logic [ISSUE_NUM*ADDR_WIDTH-1:0] mem_addr,
  input  logic                            except_valid,
  input  logic                            eret_valid,
  input  logic                            snoop_valid,
  input  logic [ADDR_WIDTH-1:0]           snoop_addr,
  output logic                            dc_req,
  output logic [ADDR_WIDTH-1:0]           dc_addr,
  input  logic                            dc_ack,
  output logic                            sc_stall,
  output logic                            sc_result_valid,
  output logic                            sc_result,
  output logic [SLOT_W-1:0]               sc_slot,
  output logic                            ll_bit,
  output logic [ADDR_WIDTH-1:0]           link_addr
);

  typedef enum logic [1:0] {
    IDLE,
    LINKED,
    SC_ISSUE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [SLOT_W-1:0]       pend_slot;
  logic [SLOT_W-1:0]       pend_slot_next;
  logic [ADDR_WIDTH-1:0]   link_addr_next;
  logic [ADDR_WIDTH-1:0]   dc_addr_next;
  logic                    res_valid_next;
  logic                    res_next;
  logic [SLOT_W-1:0]       res_slot_next;

  logic                    op_found;
  logic                    op_is_ll;
  logic [SLOT_W-1:0]       op_slot;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic                    snoop_hit;
  logic                    op_hit;

  function automatic logic granule_match(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [ADDR_WIDTH-1:0] b);
    return a[ADDR_WIDTH-1:LINE_OFFSET] == b[ADDR_WIDTH-1:LINE_OFFSET];
  endfunction

  // Slot select: scan from the top down so the lowest active slot is the
  // last one written and therefore wins if issue ever sends more than one.
  // Within a slot an LL takes precedence over an SC.
  always_comb begin
    op_found = 1'b0;
    op_is_ll = 1'b0;
    op_slot  = '0;
    op_addr  = '0;
    for (int i = ISSUE_NUM - 1; i >= 0; i--) begin
      if (ll_valid[i] || sc_valid[i]) begin
        op_found = 1'b1;
        op_is_ll = ll_valid[i];
        op_slot  = SLOT_W'(i);
        op_addr  = mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign snoop_hit = snoop_valid && granule_match(snoop_addr, link_addr);
  assign op_hit    = granule_match(op_addr, link_addr);

  // Next-state logic. Result fields hold their value between pulses; only
  // the valid bit is defaulted low so every pulse lasts exactly one cycle.
  // Exceptions/ERETs flush whatever memory op shares their cycle. Once an SC
  // is outstanding the memory stage is stalled, so slot inputs are ignored,
  // and a D-cache ack always beats a snoop or exception in the same cycle.
  always_comb begin
    state_next     = state;
    link_addr_next = link_addr;
    dc_addr_next   = dc_addr;
    pend_slot_next = pend_slot;
    res_valid_next = 1'b0;
    res_next       = sc_result;
    res_slot_next  = sc_slot;
    case (state)
      IDLE: begin
        if (except_valid || eret_valid) begin
          state_next = IDLE;
        end else if (op_found && op_is_ll) begin
          link_addr_next = op_addr;
          state_next     = LINKED;
        end else if (op_found) begin
          res_valid_next = 1'b1;
          res_next       = 1'b0;
          res_slot_next  = op_slot;
        end
      end
      LINKED: begin
        if (except_valid || eret_valid) begin
          state_next = IDLE;
        end else if (snoop_hit) begin
          // A snoop on the reserved granule kills the link and any SC racing it.
          state_next = IDLE;
          if (op_found && !op_is_ll) begin
            res_valid_next = 1'b1;
            res_next       = 1'b0;
            res_slot_next  = op_slot;
          end
        end else if (op_found && op_is_ll) begin
          link_addr_next = op_addr;
        end else if (op_found) begin
          if (op_hit) begin
            state_next     = SC_ISSUE;
            dc_addr_next   = op_addr;
            pend_slot_next = op_slot;
          end else begin
            state_next     = IDLE;
            res_valid_next = 1'b1;
            res_next       = 1'b0;
            res_slot_next  = op_slot;
          end
        end
      end
      SC_ISSUE: begin
        if (dc_ack) begin
          state_next     = IDLE;
          res_valid_next = 1'b1;
          res_next       = 1'b1;
          res_slot_next  = pend_slot;
        end else if (except_valid) begin
          state_next = IDLE;
        end else if (snoop_hit) begin
          state_next     = IDLE;
          res_valid_next = 1'b1;
          res_next       = 1'b0;
          res_slot_next  = pend_slot;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; dc_req/sc_stall/ll_bit are registered decodes
  // of the next state so they clear together with the state on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pend_slot       <= '0;
      link_addr       <= '0;
      dc_addr         <= '0;
      dc_req          <= 1'b0;
      sc_stall        <= 1'b0;
      ll_bit          <= 1'b0;
      sc_result_valid <= 1'b0;
      sc_result       <= 1'b0;
      sc_slot         <= '0;
    end else begin
      state           <= state_next;
      pend_slot       <= pend_slot_next;
      link_addr       <= link_addr_next;
      dc_addr         <= dc_addr_next;
      dc_req          <= (state_next == SC_ISSUE);
      sc_stall        <= (state_next == SC_ISSUE);
      ll_bit          <= (state_next != IDLE);
      sc_result_valid <= res_valid_next;
      sc_result       <= res_next;
      sc_slot         <= res_slot_next;
    end
  end

endmodule
